// File: rtl/toe_req_issuer.sv
// Host command stage for the TOE connection table: Avalon-MM register file plus a
// single-outstanding req_code/reply handshake with timeout, guard release and done interrupt.
module toe_req_issuer #(
  parameter int TIMEOUT = 1024,
  parameter int GUARD   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [3:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [1:0]  req_code,
  output logic [7:0]  id_out,
  input  logic [7:0]  reply,
  output logic [31:0] ip_src,
  output logic [31:0] ip_dst,
  output logic [47:0] mac_src,
  output logic [47:0] mac_dst,
  output logic [15:0] port_src,
  output logic [15:0] port_dst,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    code_q, code_d;
  logic [1:0]    req_code_q, req_code_d;
  logic [7:0]    reply_q, reply_d;
  logic          busy_q, busy_d, done_q, done_d, tmo_q, tmo_d, err_q, err_d;
  logic [31:0]   readdata_q, readdata_d;
  logic [31:0]   ip_src_q, ip_src_d, ip_dst_q, ip_dst_d;
  logic [47:0]   mac_src_q, mac_src_d, mac_dst_q, mac_dst_d;
  logic [15:0]   port_src_q, port_src_d, port_dst_q, port_dst_d;
  logic [7:0]    id_q, id_d;

  logic wr, rd, wr_guarded;

  // Valid/ready: the Avalon slave never stalls; a write or read strobe qualified by
  // chipselect is accepted on the edge where it is sampled, and readdata is valid one cycle later.
  assign wr = chipselect & write;
  assign rd = chipselect & read;
  assign wr_guarded = (address == 4'd0) || ((address >= 4'd2) && (address <= 4'd9));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    req_code_d = req_code_q;
    reply_d    = reply_q;
    busy_d     = busy_q;
    done_d     = done_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    readdata_d = readdata_q;
    ip_src_d   = ip_src_q;
    ip_dst_d   = ip_dst_q;
    mac_src_d  = mac_src_q;
    mac_dst_d  = mac_dst_q;
    port_src_d = port_src_q;
    port_dst_d = port_dst_q;
    id_d       = id_q;

    if (rd) begin
      case (address)
        4'd1:    readdata_d = {27'b0, err_q, tmo_q, done_q, busy_q, 1'b0};
        4'd2:    readdata_d = ip_src_q;
        4'd3:    readdata_d = ip_dst_q;
        4'd4:    readdata_d = mac_src_q[31:0];
        4'd5:    readdata_d = {16'b0, mac_src_q[47:32]};
        4'd6:    readdata_d = mac_dst_q[31:0];
        4'd7:    readdata_d = {16'b0, mac_dst_q[47:32]};
        4'd8:    readdata_d = {port_src_q, port_dst_q};
        4'd9:    readdata_d = {24'b0, id_q};
        4'd10:   readdata_d = {24'b0, reply_q};
        default: readdata_d = 32'b0;
      endcase
      if (address == 4'd1)  err_d  = 1'b0;
      if (address == 4'd10) done_d = 1'b0;
    end

    // Tuple registers only move while idle, which keeps the table-facing outputs frozen
    // for the whole request; an attempted write while busy is dropped and flagged.
    if (wr && busy_q && wr_guarded) err_d = 1'b1;
    if (wr && !busy_q) begin
      case (address)
        4'd2:    ip_src_d = writedata;
        4'd3:    ip_dst_d = writedata;
        4'd4:    mac_src_d[31:0]  = writedata;
        4'd5:    mac_src_d[47:32] = writedata[15:0];
        4'd6:    mac_dst_d[31:0]  = writedata;
        4'd7:    mac_dst_d[47:32] = writedata[15:0];
        4'd8:    {port_src_d, port_dst_d} = writedata;
        4'd9:    id_d = writedata[7:0];
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (wr && (address == 4'd0) && (writedata[1:0] != 2'b00)) begin
          code_d  = writedata[1:0];
          busy_d  = 1'b1;
          tmo_d   = 1'b0;
          done_d  = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        req_code_d = code_q;
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (reply != 8'd0) begin
          reply_d    = reply;
          req_code_d = 2'b00;
          cnt_d      = '0;
          state_d    = S_RELEASE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          reply_d    = 8'd0;
          req_code_d = 2'b00;
          tmo_d      = 1'b1;
          cnt_d      = '0;
          state_d    = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        // Holding req_code at 00 lets the table block fall back into its wait state.
        if (cnt_q == CW'(GUARD - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      code_q     <= 2'b00;
      req_code_q <= 2'b00;
      reply_q    <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      err_q      <= 1'b0;
      readdata_q <= 32'b0;
      ip_src_q   <= 32'b0;
      ip_dst_q   <= 32'b0;
      mac_src_q  <= 48'b0;
      mac_dst_q  <= 48'b0;
      port_src_q <= 16'b0;
      port_dst_q <= 16'b0;
      id_q       <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      req_code_q <= req_code_d;
      reply_q    <= reply_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      readdata_q <= readdata_d;
      ip_src_q   <= ip_src_d;
      ip_dst_q   <= ip_dst_d;
      mac_src_q  <= mac_src_d;
      mac_dst_q  <= mac_dst_d;
      port_src_q <= port_src_d;
      port_dst_q <= port_dst_d;
      id_q       <= id_d;
    end
  end

  assign readdata  = readdata_q;
  assign irq       = done_q;
  assign req_code  = req_code_q;
  assign id_out    = id_q;
  assign ip_src    = ip_src_q;
  assign ip_dst    = ip_dst_q;
  assign mac_src   = mac_src_q;
  assign mac_dst   = mac_dst_q;
  assign port_src  = port_src_q;
  assign port_dst  = port_dst_q;
  assign dbg_state = state_q;

endmodule
